// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard unit for a 5-stage in-order core.
// Provides EX-stage operand forwarding, load-use bubble insertion,
// branch flushes and a full-pipeline freeze on data memory busy.
// Optional macro HAZARD_PERF_CNT_EN adds stall/flush performance counters;
// without it the counter ports are tied to zero.
module hazard_ctrl #(
   parameter int REG_AW            = 5,
   parameter int LOAD_STALL_CYCLES = 1,
   parameter int CNT_W             = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [REG_AW-1:0] rs1_d,
   input  logic [REG_AW-1:0] rs2_d,
   input  logic [REG_AW-1:0] rs1_e,
   input  logic [REG_AW-1:0] rs2_e,
   input  logic [REG_AW-1:0] rd_e,
   input  logic [REG_AW-1:0] rd_m,
   input  logic [REG_AW-1:0] rd_w,
   input  logic              reg_write_m,
   input  logic              reg_write_w,
   input  logic              mem_read_e,
   input  logic              pc_src_e,
   input  logic              mem_busy,
   output logic [1:0]        forward_a_e,
   output logic [1:0]        forward_b_e,
   output logic              stall_f,
   output logic              stall_d,
   output logic              stall_e,
   output logic              stall_m,
   output logic              flush_d,
   output logic              flush_e,
   output logic [CNT_W-1:0]  stall_cnt,
   output logic [CNT_W-1:0]  flush_cnt
);

   typedef enum logic {
      IDLE     = 1'b0,
      LD_STALL = 1'b1
   } state_t;

   localparam logic [2:0] LD_INIT = 3'(LOAD_STALL_CYCLES - 1);

   state_t     state;
   logic [2:0] ld_cnt;
   logic       load_use;

   // Load in Execute whose destination feeds the instruction in Decode.
   assign load_use = mem_read_e && (rd_e != '0) &&
                     ((rd_e == rs1_d) || (rd_e == rs2_d));

   // Operand forwarding: Memory result wins over Writeback, x0 never forwards.
   always_comb begin
      // NOTE: every output of a combinational block gets a default first so no latch is inferred.
      forward_a_e = 2'b00;
      forward_b_e = 2'b00;
      if (!rst) begin
         if (reg_write_m && (rd_m != '0) && (rd_m == rs1_e))
            forward_a_e = 2'b10;
         else if (reg_write_w && (rd_w != '0) && (rd_w == rs1_e))
            forward_a_e = 2'b01;
         if (reg_write_m && (rd_m != '0) && (rd_m == rs2_e))
            forward_b_e = 2'b10;
         else if (reg_write_w && (rd_w != '0) && (rd_w == rs2_e))
            forward_b_e = 2'b01;
      end
   end

   // Stall/flush decode in priority order: reset, freeze, branch, bubbles.
   always_comb begin
      stall_f = 1'b0;
      stall_d = 1'b0;
      stall_e = 1'b0;
      stall_m = 1'b0;
      flush_d = 1'b0;
      flush_e = 1'b0;
      if (rst) begin
         // everything already low
      end else if (mem_busy) begin
         stall_f = 1'b1;
         stall_d = 1'b1;
         stall_e = 1'b1;
         stall_m = 1'b1;
      end else if (pc_src_e) begin
         flush_d = 1'b1;
         flush_e = 1'b1;
      end else if ((state == LD_STALL) || load_use) begin
         stall_f = 1'b1;
         stall_d = 1'b1;
         flush_e = 1'b1;
      end
   end

   // Bubble FSM: counts remaining load-use bubbles; freezes under mem_busy.
   always_ff @(posedge clk) begin
      // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
      if (rst) begin
         state  <= IDLE;
         ld_cnt <= 3'd0;
      end else if (mem_busy) begin
         state  <= state;
         ld_cnt <= ld_cnt;
      end else if (pc_src_e) begin
         state  <= IDLE;
         ld_cnt <= 3'd0;
      end else if (state == LD_STALL) begin
         if (ld_cnt == 3'd1) begin
            state  <= IDLE;
            ld_cnt <= 3'd0;
         end else begin
            ld_cnt <= ld_cnt - 3'd1;
         end
      end else if (load_use && (LOAD_STALL_CYCLES > 1)) begin
         state  <= LD_STALL;
         ld_cnt <= LD_INIT;
      end
   end

`ifdef HAZARD_PERF_CNT_EN
   // Performance counters: fetch-stall cycles and decode-flush cycles, wrapping.
   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         if (stall_f) stall_cnt <= stall_cnt + CNT_W'(1);
         if (flush_d) flush_cnt <= flush_cnt + CNT_W'(1);
      end
   end
`else
   assign stall_cnt = '0;
   assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed scenarios plus randomized traffic, every cycle
// compared against a pending-bubble-count reference model.
module tb_hazard_ctrl;

   localparam int AW  = 5;
   localparam int LSC = 3;
   localparam int CW  = 8;

   logic          clk = 1'b0;
   logic          rst;
   logic [AW-1:0] rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w;
   logic          reg_write_m, reg_write_w, mem_read_e, pc_src_e, mem_busy;
   logic [1:0]    forward_a_e, forward_b_e;
   logic          stall_f, stall_d, stall_e, stall_m, flush_d, flush_e;
   logic [CW-1:0] stall_cnt, flush_cnt;

   int n_cmp = 0;
   int n_err = 0;

   // reference model state
   int pend       = 0;
   int m_stall    = 0;
   int m_flush    = 0;
   bit cnt_known  = 1'b0;

   // most recent sampled outputs, for directed pattern checks
   logic [3:0] last_stalls;
   logic [1:0] last_flush;
   logic [7:0] sf_hist;

   always #5 clk = ~clk;

   hazard_ctrl #(
      .REG_AW(AW), .LOAD_STALL_CYCLES(LSC), .CNT_W(CW)
   ) dut (
      .clk(clk), .rst(rst),
      .rs1_d(rs1_d), .rs2_d(rs2_d), .rs1_e(rs1_e), .rs2_e(rs2_e), .rd_e(rd_e),
      .rd_m(rd_m), .rd_w(rd_w), .reg_write_m(reg_write_m), .reg_write_w(reg_write_w),
      .mem_read_e(mem_read_e), .pc_src_e(pc_src_e), .mem_busy(mem_busy),
      .forward_a_e(forward_a_e), .forward_b_e(forward_b_e),
      .stall_f(stall_f), .stall_d(stall_d), .stall_e(stall_e), .stall_m(stall_m),
      .flush_d(flush_d), .flush_e(flush_e),
      .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   function automatic logic [1:0] fwd(input logic [AW-1:0] rs);
      if (reg_write_m && rd_m != 0 && rd_m == rs) return 2'b10;
      if (reg_write_w && rd_w != 0 && rd_w == rs) return 2'b01;
      return 2'b00;
   endfunction

   task automatic idle_inputs();
      rs1_d = '0; rs2_d = '0; rs1_e = '0; rs2_e = '0; rd_e = '0; rd_m = '0; rd_w = '0;
      reg_write_m = 0; reg_write_w = 0; mem_read_e = 0; pc_src_e = 0; mem_busy = 0;
   endtask

   // One clock: compare all outputs against the model, then advance the model.
   task automatic tick();
      logic       haz;
      logic [3:0] e_st;
      logic [1:0] e_fl;
      logic [1:0] e_fa, e_fb;
      #1;
      haz  = mem_read_e && rd_e != 0 && (rd_e == rs1_d || rd_e == rs2_d);
      e_st = 4'b0000;
      e_fl = 2'b00;
      e_fa = rst ? 2'b00 : fwd(rs1_e);
      e_fb = rst ? 2'b00 : fwd(rs2_e);
      if (rst)             begin e_st = 4'b0000; e_fl = 2'b00; end
      else if (mem_busy)   begin e_st = 4'b1111; e_fl = 2'b00; end
      else if (pc_src_e)   begin e_st = 4'b0000; e_fl = 2'b11; end
      else if (pend > 0 || haz) begin e_st = 4'b1100; e_fl = 2'b01; end

      check("fwd_a", 32'(forward_a_e), 32'(e_fa));
      check("fwd_b", 32'(forward_b_e), 32'(e_fb));
      check("stalls_fdem", 32'({stall_f, stall_d, stall_e, stall_m}), 32'(e_st));
      check("flush_de", 32'({flush_d, flush_e}), 32'(e_fl));
`ifdef HAZARD_PERF_CNT_EN
      if (cnt_known) begin
         check("stall_cnt", 32'(stall_cnt), 32'(m_stall));
         check("flush_cnt", 32'(flush_cnt), 32'(m_flush));
      end
`else
      check("stall_cnt_tied", 32'(stall_cnt), 32'd0);
      check("flush_cnt_tied", 32'(flush_cnt), 32'd0);
`endif
      last_stalls = {stall_f, stall_d, stall_e, stall_m};
      last_flush  = {flush_d, flush_e};
      sf_hist     = {sf_hist[6:0], stall_f};

      if (rst) begin
         pend = 0; m_stall = 0; m_flush = 0; cnt_known = 1'b1;
      end else begin
         if (mem_busy)      ;
         else if (pc_src_e) pend = 0;
         else if (pend > 0) pend--;
         else if (haz)      pend = LSC - 1;
         m_stall = (m_stall + int'(e_st[3])) % (1 << CW);
         m_flush = (m_flush + int'(e_fl[1])) % (1 << CW);
      end
      @(negedge clk);
   endtask

   task automatic load_use_rs2();
      idle_inputs();
      mem_read_e = 1; rd_e = 5'd7; rs2_d = 5'd7;
   endtask

   initial begin
      sf_hist = '0;
      idle_inputs();
      rst = 1;
      @(negedge clk);
      tick(); tick();
      rst = 0;

      // forwarding selects
      rd_m = 5; rd_w = 5; rs1_e = 5; reg_write_m = 1; reg_write_w = 1;
      #1 check("fwd_mem_prio", 32'(forward_a_e), 32'(2'b10));
      tick();
      reg_write_m = 0;
      #1 check("fwd_wb", 32'(forward_a_e), 32'(2'b01));
      tick();
      reg_write_m = 1; rd_m = 0; rd_w = 0; rs1_e = 0;
      #1 check("fwd_x0", 32'(forward_a_e), 32'(2'b00));
      tick();

      // load-use: exactly LSC bubbles
      load_use_rs2(); tick();
      idle_inputs();  tick(); tick(); tick(); tick();
      check("ld_bubbles", 32'(sf_hist[4:0]), 32'(5'b11100));

      // branch in second bubble cancels the rest
      load_use_rs2(); tick();
      idle_inputs(); pc_src_e = 1; tick();
      check("br_in_bubble_flush", 32'({last_stalls, last_flush}), 32'(6'b000011));
      pc_src_e = 0; tick();
      check("br_after_quiet", 32'({last_stalls, last_flush}), 32'(6'b000000));

      // freeze during LD_STALL holds remaining bubbles
      load_use_rs2(); tick();
      idle_inputs(); mem_busy = 1;
      repeat (4) tick();
      check("freeze_stalls", 32'({last_stalls, last_flush}), 32'(6'b111100));
      mem_busy = 0; tick(); tick(); tick();
      check("freeze_resume_bubbles", 32'(sf_hist[6:0]), 32'(7'b1111110));

      // branch held through a freeze
      idle_inputs(); mem_busy = 1; pc_src_e = 1; tick(); tick();
      check("busy_masks_branch", 32'(last_flush), 32'(2'b00));
      mem_busy = 0; tick();
      check("branch_after_busy", 32'(last_flush), 32'(2'b11));
      pc_src_e = 0; tick();

      // counters: 3 bubbles + 1 branch, then reset clears
      rst = 1; tick(); rst = 0;
      load_use_rs2(); tick();
      idle_inputs(); tick(); tick();
      pc_src_e = 1; tick();
      pc_src_e = 0; tick();
`ifdef HAZARD_PERF_CNT_EN
      check("perf_stall3", 32'(stall_cnt), 32'd3);
      check("perf_flush1", 32'(flush_cnt), 32'd1);
`else
      check("perf_tied_s", 32'(stall_cnt), 32'd0);
      check("perf_tied_f", 32'(flush_cnt), 32'd0);
`endif
      rst = 1; load_use_rs2(); tick();
      check("rst_overrides", 32'({last_stalls, last_flush}), 32'(6'b000000));
      rst = 0; idle_inputs(); tick();
      check("perf_rst_s", 32'(stall_cnt), 32'd0);
      check("perf_rst_f", 32'(flush_cnt), 32'd0);

      // randomized traffic on a small register range to provoke hazards
      for (int i = 0; i < 3000; i++) begin
         rs1_d = AW'($urandom_range(0, 3)); rs2_d = AW'($urandom_range(0, 3));
         rs1_e = AW'($urandom_range(0, 3)); rs2_e = AW'($urandom_range(0, 3));
         rd_e  = AW'($urandom_range(0, 3)); rd_m  = AW'($urandom_range(0, 3));
         rd_w  = AW'($urandom_range(0, 3));
         reg_write_m = 1'($urandom_range(0, 1));
         reg_write_w = 1'($urandom_range(0, 1));
         mem_read_e  = ($urandom_range(0, 2) == 0);
         pc_src_e    = ($urandom_range(0, 7) == 0);
         mem_busy    = ($urandom_range(0, 5) == 0);
         rst         = ($urandom_range(0, 60) == 0);
         tick();
      end
      rst = 0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
